player_key_decoder: RTL and testbench
=====================================

// Module: player_key_decoder
// PURPOSE
//  Keyboard-side producer of the player movement interface. Consumes PS/2 set-2 scan bytes,
//  tracks make/break (incl. E0-extended) state of the move/pause keys, and drives the
//  active-low moveLeft/moveRight levels and pause level sampled by the player motion block.
//  Outputs change only on startOfFrame, so the motion block sees stable commands per frame.
// PARAMETERS
//  LEFT_CODE       8'h6B  extended (E0) code of left arrow
//  RIGHT_CODE      8'h74  extended (E0) code of right arrow
//  ALT_LEFT_CODE   8'h1C  non-extended alternate left key (A)
//  ALT_RIGHT_CODE  8'h23  non-extended alternate right key (D)
//  PAUSE_CODE      8'h4D  non-extended pause toggle key (P)
//  TIMEOUT_FRAMES  16     frames without a repeat make before a held key is force-released
// PORTS
//  clk           in   1  system clock
//  resetN        in   1  synchronous active-low reset
//  kbdByte       in   8  received scan byte, valid when kbdByteValid=1
//  kbdByteValid  in   1  one-cycle strobe per received byte
//  startOfFrame  in   1  one-cycle pulse per frame (30 Hz)
//  moveLeft      out  1  active-low: 0 = move left this frame
//  moveRight     out  1  active-low: 0 = move right this frame
//  pause         out  1  active-high pause level
//  protoErr      out  1  one-cycle pulse on illegal prefix sequence
// BEHAVIOUR
//  Reset (resetN=0 at clk edge): moveLeft=1, moveRight=1, pause=0, protoErr=0, FSM=IDLE,
//   all held/sticky flags 0, timeout counter 0. Reset mid-sequence discards partial prefixes.
//  Prefix FSM (advances only on kbdByteValid):
//   IDLE:    E0->EXT; F0->BRK; else decode non-ext make, stay IDLE
//   EXT:     F0->EXT_BRK; E0->EXT (repeat ignored); else decode ext make ->IDLE
//   BRK:     E0/F0 -> protoErr pulse, ->IDLE; else decode non-ext break ->IDLE
//   EXT_BRK: E0/F0 -> protoErr pulse, ->IDLE; else decode ext break ->IDLE
//   Unmatched codes (incl. AA, FA, FE, non-extended 6B/74, extended 1C/23/4D) ignored.
//  Held flags: leftHeld = arrowL | keyA (two independent bits, OR'ed); same for right.
//   Make sets bit, break clears bit; repeated makes (typematic) are idempotent.
//  Sticky flags: leftSeen/rightSeen set on any left/right make in current frame, so a
//   press+release inside one frame still yields exactly one frame of motion.
//  Frame update, cycle of startOfFrame=1 (registered, 1-cycle latency to outputs):
//   L = leftHeld|leftSeen, R = rightHeld|rightSeen (values before this cycle's byte)
//   L&R -> moveLeft=1,moveRight=1 (conflict = no motion); else moveLeft=~L, moveRight=~R
//   pause <= pause ^ pauseTogglePending; then clear sticky flags and pending toggle.
//  Pause toggle pending set on P make only when P not already held (repeat does not toggle);
//   two fresh P presses in one frame cancel (XOR).
//  kbdByteValid coincident with startOfFrame: byte is processed normally; its effect appears
//   at the following frame update, never lost.
//  Outputs hold between frames; protoErr is the only non-frame-aligned output.
// CONFIGURATION
//  STUCK_KEY_TIMEOUT_EN defined: counter increments each startOfFrame while any movement
//   held bit is set, clears on any movement make or when none held; on reaching
//   TIMEOUT_FRAMES all movement held bits clear (counter saturates, then resets to 0);
//   recovers from lost break codes. Pause unaffected.
//  Not defined: no counter; held bits clear only on break codes or reset.
// TESTING
//  E0 6B, then SOF -> moveLeft=0,moveRight=1 one cycle after SOF; E0 F0 6B, SOF -> moveLeft=1
//  1C then F0 1C within one frame, SOF -> moveLeft=0 for exactly one frame, 1 next frame
//  E0 6B + 23 held, SOF -> moveLeft=1,moveRight=1; release 23 (F0 23), SOF -> moveLeft=0
//  4D, 4D, 4D (repeat), F0 4D, SOF -> pause=1; 4D, F0 4D, SOF -> pause=0
//  F0 F0 -> protoErr pulse 1 cycle, FSM IDLE; following 23 is treated as make
//  (EN) 74 with no break, 16 SOFs no repeat -> moveRight returns 1; (no EN) stays 0

Source files
------------

// File: rtl/player_key_decoder.sv
// player_key_decoder
// Turns PS/2 set-2 scan bytes into frame-aligned movement and pause commands.
// The prefix FSM tracks E0/F0 prefixes. Two kinds of per-key state are kept:
//   - held bits: set by make codes, cleared by break codes
//   - sticky "seen" bits: make sure a short tap still produces one frame of motion
// moveLeft, moveRight and pause are updated only on startOfFrame.
// Optional feature macro: STUCK_KEY_TIMEOUT_EN. When defined, a frame counter
// force-releases movement keys if no repeat make arrives for TIMEOUT_FRAMES frames.
module player_key_decoder #(
    parameter logic [7:0] LEFT_CODE      = 8'h6B,
    parameter logic [7:0] RIGHT_CODE     = 8'h74,
    parameter logic [7:0] ALT_LEFT_CODE  = 8'h1C,
    parameter logic [7:0] ALT_RIGHT_CODE = 8'h23,
    parameter logic [7:0] PAUSE_CODE     = 8'h4D
`ifdef STUCK_KEY_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_FRAMES = 16
`endif
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] kbdByte,
    input  logic       kbdByteValid,
    input  logic       startOfFrame,
    output logic       moveLeft,
    output logic       moveRight,
    output logic       pause,
    output logic       protoErr
);

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic is_prefix_s;
    logic ext_make_s, ext_brk_s, nx_make_s, nx_brk_s, proto_err_s;
    logic set_arrow_l_s, clr_arrow_l_s, set_arrow_r_s, clr_arrow_r_s;
    logic set_key_a_s, clr_key_a_s, set_key_d_s, clr_key_d_s;
    logic p_make_s, p_brk_s, move_make_s;

    logic arrow_l_r, arrow_r_r, key_a_r, key_d_r, p_held_r;
    logic arrow_l_next_s, arrow_r_next_s, key_a_next_s, key_d_next_s, p_held_next_s;
    logic left_seen_r, right_seen_r, toggle_pend_r;
    logic left_seen_next_s, right_seen_next_s, toggle_pend_next_s;
    logic any_move_held_s, timeout_hit_s;
    logic frame_l_s, frame_r_s;
    logic move_left_next_s, move_right_next_s, pause_next_s;

    assign is_prefix_s = (kbdByte == PFX_EXT) || (kbdByte == PFX_BRK);

    // Prefix state register; reset drops any partial prefix sequence.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Prefix FSM next state; only a valid byte can move it.
    always_comb begin
        state_next_s = state_r;
        if (kbdByteValid) begin
            case (state_r)
                ST_IDLE: begin
                    if (kbdByte == PFX_EXT)      state_next_s = ST_EXT;
                    else if (kbdByte == PFX_BRK) state_next_s = ST_BRK;
                    else                         state_next_s = ST_IDLE;
                end
                ST_EXT: begin
                    if (kbdByte == PFX_BRK)      state_next_s = ST_EXT_BRK;
                    else if (kbdByte == PFX_EXT) state_next_s = ST_EXT;
                    else                         state_next_s = ST_IDLE;
                end
                ST_BRK:     state_next_s = ST_IDLE;
                ST_EXT_BRK: state_next_s = ST_IDLE;
                default:    state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM outputs: classify the byte as make/break (ext or not) or a protocol error.
    always_comb begin
        ext_make_s  = 1'b0;
        ext_brk_s   = 1'b0;
        nx_make_s   = 1'b0;
        nx_brk_s    = 1'b0;
        proto_err_s = 1'b0;
        if (kbdByteValid) begin
            case (state_r)
                ST_IDLE:    nx_make_s = !is_prefix_s;
                ST_EXT:     ext_make_s = !is_prefix_s;
                ST_BRK: begin
                    proto_err_s = is_prefix_s;
                    nx_brk_s    = !is_prefix_s;
                end
                ST_EXT_BRK: begin
                    proto_err_s = is_prefix_s;
                    ext_brk_s   = !is_prefix_s;
                end
                default: proto_err_s = 1'b0;
            endcase
        end else begin
            proto_err_s = 1'b0;
        end
    end

    // Key events. Extended and non-extended codes are matched separately,
    // so a non-extended 6B or an extended 1C is simply ignored.
    always_comb begin
        set_arrow_l_s = ext_make_s && (kbdByte == LEFT_CODE);
        clr_arrow_l_s = ext_brk_s  && (kbdByte == LEFT_CODE);
        set_arrow_r_s = ext_make_s && (kbdByte == RIGHT_CODE);
        clr_arrow_r_s = ext_brk_s  && (kbdByte == RIGHT_CODE);
        set_key_a_s   = nx_make_s  && (kbdByte == ALT_LEFT_CODE);
        clr_key_a_s   = nx_brk_s   && (kbdByte == ALT_LEFT_CODE);
        set_key_d_s   = nx_make_s  && (kbdByte == ALT_RIGHT_CODE);
        clr_key_d_s   = nx_brk_s   && (kbdByte == ALT_RIGHT_CODE);
        p_make_s      = nx_make_s  && (kbdByte == PAUSE_CODE);
        p_brk_s       = nx_brk_s   && (kbdByte == PAUSE_CODE);
        move_make_s   = set_arrow_l_s | set_arrow_r_s | set_key_a_s | set_key_d_s;
    end

    assign any_move_held_s = arrow_l_r | arrow_r_r | key_a_r | key_d_r;

`ifdef STUCK_KEY_TIMEOUT_EN
    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] frame_cnt_r;
    logic [CNT_W-1:0] frame_cnt_next_s;

    // A fresh movement make always wins over the timeout in the same cycle.
    assign timeout_hit_s = startOfFrame && any_move_held_s && !move_make_s &&
                           (frame_cnt_r == CNT_LAST);

    // Stuck-key counter next value: counts frames while a movement key is held.
    always_comb begin
        frame_cnt_next_s = frame_cnt_r;
        if (move_make_s || !any_move_held_s) begin
            frame_cnt_next_s = CNT_ZERO;
        end else if (startOfFrame) begin
            if (timeout_hit_s) frame_cnt_next_s = CNT_ZERO;
            else               frame_cnt_next_s = frame_cnt_r + CNT_ONE;
        end else begin
            frame_cnt_next_s = frame_cnt_r;
        end
    end

    // Stuck-key counter register.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            frame_cnt_r <= CNT_ZERO;
        end else begin
            frame_cnt_r <= frame_cnt_next_s;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Held-bit next values. Repeated makes are idempotent.
    // A timeout force-releases all movement keys.
    always_comb begin
        arrow_l_next_s = timeout_hit_s ? 1'b0 : (set_arrow_l_s | (arrow_l_r & ~clr_arrow_l_s));
        arrow_r_next_s = timeout_hit_s ? 1'b0 : (set_arrow_r_s | (arrow_r_r & ~clr_arrow_r_s));
        key_a_next_s   = timeout_hit_s ? 1'b0 : (set_key_a_s   | (key_a_r   & ~clr_key_a_s));
        key_d_next_s   = timeout_hit_s ? 1'b0 : (set_key_d_s   | (key_d_r   & ~clr_key_d_s));
        p_held_next_s  = p_make_s | (p_held_r & ~p_brk_s);
    end

    // Sticky and pending-toggle next values. On a frame update the old values are
    // consumed first, so a byte arriving on the same cycle counts for the next frame.
    always_comb begin
        if (startOfFrame) begin
            left_seen_next_s   = set_arrow_l_s | set_key_a_s;
            right_seen_next_s  = set_arrow_r_s | set_key_d_s;
            toggle_pend_next_s = p_make_s & ~p_held_r;
        end else begin
            left_seen_next_s   = left_seen_r  | set_arrow_l_s | set_key_a_s;
            right_seen_next_s  = right_seen_r | set_arrow_r_s | set_key_d_s;
            toggle_pend_next_s = toggle_pend_r ^ (p_make_s & ~p_held_r);
        end
    end

    // Key-state registers.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            arrow_l_r     <= 1'b0;
            arrow_r_r     <= 1'b0;
            key_a_r       <= 1'b0;
            key_d_r       <= 1'b0;
            p_held_r      <= 1'b0;
            left_seen_r   <= 1'b0;
            right_seen_r  <= 1'b0;
            toggle_pend_r <= 1'b0;
        end else begin
            arrow_l_r     <= arrow_l_next_s;
            arrow_r_r     <= arrow_r_next_s;
            key_a_r       <= key_a_next_s;
            key_d_r       <= key_d_next_s;
            p_held_r      <= p_held_next_s;
            left_seen_r   <= left_seen_next_s;
            right_seen_r  <= right_seen_next_s;
            toggle_pend_r <= toggle_pend_next_s;
        end
    end

    // Frame command: opposing requests cancel to "no motion".
    always_comb begin
        frame_l_s = arrow_l_r | key_a_r | left_seen_r;
        frame_r_s = arrow_r_r | key_d_r | right_seen_r;
        if (startOfFrame) begin
            move_left_next_s  = (frame_l_s & frame_r_s) ? 1'b1 : ~frame_l_s;
            move_right_next_s = (frame_l_s & frame_r_s) ? 1'b1 : ~frame_r_s;
            pause_next_s      = pause ^ toggle_pend_r;
        end else begin
            move_left_next_s  = moveLeft;
            move_right_next_s = moveRight;
            pause_next_s      = pause;
        end
    end

    // Output registers. protoErr is a one-cycle pulse; the others hold between frames.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            moveLeft  <= 1'b1;
            moveRight <= 1'b1;
            pause     <= 1'b0;
            protoErr  <= 1'b0;
        end else begin
            moveLeft  <= move_left_next_s;
            moveRight <= move_right_next_s;
            pause     <= pause_next_s;
            protoErr  <= proto_err_s;
        end
    end

endmodule

// File: tb/tb_player_key_decoder.sv
// Testbench for player_key_decoder.
// It runs three parts:
//   1. A directed vector table.
//   2. Hand-written reset and stuck-key sequences.
//   3. Random bytes checked against a key-level reference model.
module tb_player_key_decoder;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [7:0] kbdByte = 8'h00;
    logic       kbdByteValid = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       moveLeft, moveRight, pause, protoErr;

    player_key_decoder dut (
        .clk(clk), .resetN(resetN), .kbdByte(kbdByte), .kbdByteValid(kbdByteValid),
        .startOfFrame(startOfFrame), .moveLeft(moveLeft), .moveRight(moveRight),
        .pause(pause), .protoErr(protoErr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model (key-level) ----------------
    bit held_m [0:511];             // index {ext, code}
    bit m_ext, m_brk;
    bit seen_l, seen_r, pend;
    bit m_ml, m_mr, m_pause, m_err;
    int idle_frames;

    function automatic bit left_held();
        return held_m[{1'b1, 8'h6B}] | held_m[{1'b0, 8'h1C}];
    endfunction

    function automatic bit right_held();
        return held_m[{1'b1, 8'h74}] | held_m[{1'b0, 8'h23}];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 512; i++) held_m[i] = 1'b0;
        m_ext = 0; m_brk = 0; seen_l = 0; seen_r = 0; pend = 0;
        m_ml = 1; m_mr = 1; m_pause = 0; m_err = 0; idle_frames = 0;
    endtask

    // Applies one make or break; returns 1 if it was a movement make.
    function automatic bit key_event(input bit ext, input logic [7:0] code, input bit make);
        logic [8:0] id = {ext, code};
        bit is_l = (id == {1'b1, 8'h6B}) || (id == {1'b0, 8'h1C});
        bit is_r = (id == {1'b1, 8'h74}) || (id == {1'b0, 8'h23});
        if (make && is_l) seen_l = 1;
        if (make && is_r) seen_r = 1;
        if (make && id == {1'b0, 8'h4D} && !held_m[id]) pend = ~pend;
        held_m[id] = make;
        return make && (is_l || is_r);
    endfunction

    task automatic model_step(input bit sof, input bit v, input logic [7:0] b);
        bit l, r, mm;
        mm = 0;
        m_err = 0;
        if (sof) begin
            l = left_held() | seen_l;
            r = right_held() | seen_r;
            m_ml = (l && r) ? 1'b1 : !l;
            m_mr = (l && r) ? 1'b1 : !r;
            m_pause = m_pause ^ pend;
            seen_l = 0; seen_r = 0; pend = 0;
        end
        if (v) begin
            if (m_brk) begin
                if (b == 8'hE0 || b == 8'hF0) m_err = 1;
                else mm = key_event(m_ext, b, 1'b0);
                m_ext = 0; m_brk = 0;
            end else if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else begin
                mm = key_event(m_ext, b, 1'b1);
                m_ext = 0;
            end
        end
`ifdef STUCK_KEY_TIMEOUT_EN
        if (mm || !(left_held() || right_held())) idle_frames = 0;
        else if (sof) begin
            idle_frames++;
            if (idle_frames >= 16) begin
                held_m[{1'b1, 8'h6B}] = 0; held_m[{1'b0, 8'h1C}] = 0;
                held_m[{1'b1, 8'h74}] = 0; held_m[{1'b0, 8'h23}] = 0;
                idle_frames = 0;
            end
        end
`else
        if (mm) idle_frames = 0;
`endif
    endtask

    // ---------------- driving and checking ----------------
    task automatic step(input bit sof, input bit v, input logic [7:0] b);
        startOfFrame = sof; kbdByteValid = v; kbdByte = b;
        @(posedge clk);
        #1;
        if (!resetN) model_reset();
        else model_step(sof, v, b);
        startOfFrame = 1'b0; kbdByteValid = 1'b0;
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {moveLeft, moveRight, pause, protoErr};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got {ml,mr,pause,err}=%b, required %b", name, got, exp);
        end
    endtask

    typedef struct {
        bit         sof;
        bit         v;
        logic [7:0] b;
        logic [3:0] exp;   // {moveLeft, moveRight, pause, protoErr}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit sof, input bit v, input logic [7:0] b,
                                input logic [3:0] exp);
        vec_t t;
        t.sof = sof; t.v = v; t.b = b; t.exp = exp;
        return t;
    endfunction

    logic [7:0] pool [0:9];

    initial begin
        // left arrow make, then break
        tbl.push_back(mk(0,1,8'hE0,4'b1100)); tbl.push_back(mk(0,1,8'h6B,4'b1100));
        tbl.push_back(mk(1,0,8'h00,4'b0100)); tbl.push_back(mk(0,0,8'h00,4'b0100));
        tbl.push_back(mk(0,1,8'hE0,4'b0100)); tbl.push_back(mk(0,1,8'hF0,4'b0100));
        tbl.push_back(mk(0,1,8'h6B,4'b0100)); tbl.push_back(mk(1,0,8'h00,4'b1100));
        // tap A inside one frame
        tbl.push_back(mk(0,1,8'h1C,4'b1100)); tbl.push_back(mk(0,1,8'hF0,4'b1100));
        tbl.push_back(mk(0,1,8'h1C,4'b1100)); tbl.push_back(mk(1,0,8'h00,4'b0100));
        tbl.push_back(mk(1,0,8'h00,4'b1100));
        // conflict: left arrow + D
        tbl.push_back(mk(0,1,8'hE0,4'b1100)); tbl.push_back(mk(0,1,8'h6B,4'b1100));
        tbl.push_back(mk(0,1,8'h23,4'b1100)); tbl.push_back(mk(1,0,8'h00,4'b1100));
        tbl.push_back(mk(0,1,8'hF0,4'b1100)); tbl.push_back(mk(0,1,8'h23,4'b1100));
        tbl.push_back(mk(1,0,8'h00,4'b0100)); tbl.push_back(mk(0,1,8'hE0,4'b0100));
        tbl.push_back(mk(0,1,8'hF0,4'b0100)); tbl.push_back(mk(0,1,8'h6B,4'b0100));
        tbl.push_back(mk(1,0,8'h00,4'b1100));
        // pause: typematic repeat does not toggle again
        tbl.push_back(mk(0,1,8'h4D,4'b1100)); tbl.push_back(mk(0,1,8'h4D,4'b1100));
        tbl.push_back(mk(0,1,8'h4D,4'b1100)); tbl.push_back(mk(0,1,8'hF0,4'b1100));
        tbl.push_back(mk(0,1,8'h4D,4'b1100)); tbl.push_back(mk(1,0,8'h00,4'b1110));
        tbl.push_back(mk(0,1,8'h4D,4'b1110)); tbl.push_back(mk(0,1,8'hF0,4'b1110));
        tbl.push_back(mk(0,1,8'h4D,4'b1110)); tbl.push_back(mk(1,0,8'h00,4'b1100));
        // F0 F0 -> protoErr, then 23 is a make
        tbl.push_back(mk(0,1,8'hF0,4'b1100)); tbl.push_back(mk(0,1,8'hF0,4'b1101));
        tbl.push_back(mk(0,1,8'h23,4'b1100)); tbl.push_back(mk(1,0,8'h00,4'b1000));
        tbl.push_back(mk(0,1,8'hF0,4'b1000)); tbl.push_back(mk(0,1,8'h23,4'b1000));
        tbl.push_back(mk(1,0,8'h00,4'b1100));
        // byte coincident with startOfFrame counts for the next frame
        tbl.push_back(mk(1,1,8'h1C,4'b1100)); tbl.push_back(mk(1,0,8'h00,4'b0100));
        tbl.push_back(mk(0,1,8'hF0,4'b0100)); tbl.push_back(mk(0,1,8'h1C,4'b0100));
        tbl.push_back(mk(1,0,8'h00,4'b1100));
        // repeated E0 ignored
        tbl.push_back(mk(0,1,8'hE0,4'b1100)); tbl.push_back(mk(0,1,8'hE0,4'b1100));
        tbl.push_back(mk(0,1,8'h74,4'b1100)); tbl.push_back(mk(1,0,8'h00,4'b1000));
        tbl.push_back(mk(0,1,8'hE0,4'b1000)); tbl.push_back(mk(0,1,8'hF0,4'b1000));
        tbl.push_back(mk(0,1,8'h74,4'b1000)); tbl.push_back(mk(1,0,8'h00,4'b1100));
        // non-extended 6B and extended 1C are ignored
        tbl.push_back(mk(0,1,8'h6B,4'b1100)); tbl.push_back(mk(0,1,8'hE0,4'b1100));
        tbl.push_back(mk(0,1,8'h1C,4'b1100)); tbl.push_back(mk(1,0,8'h00,4'b1100));
        // E0 F0 E0 -> protoErr, then 1C is a make
        tbl.push_back(mk(0,1,8'hE0,4'b1100)); tbl.push_back(mk(0,1,8'hF0,4'b1100));
        tbl.push_back(mk(0,1,8'hE0,4'b1101)); tbl.push_back(mk(0,1,8'h1C,4'b1100));
        tbl.push_back(mk(1,0,8'h00,4'b0100)); tbl.push_back(mk(0,1,8'hF0,4'b0100));
        tbl.push_back(mk(0,1,8'h1C,4'b0100)); tbl.push_back(mk(1,0,8'h00,4'b1100));

        model_reset();
        resetN = 1'b0;
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        check("reset_state", 4'b1100);
        resetN = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].sof, tbl[i].v, tbl[i].b);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Reset mid-sequence discards a pending F0, so 23 is a make.
        step(0, 1, 8'hF0);
        resetN = 1'b0;
        step(0, 0, 8'h00);
        check("reset_mid_seq", 4'b1100);
        resetN = 1'b1;
        step(0, 1, 8'h23);
        step(1, 0, 8'h00);
        check("after_reset_make", 4'b1000);
        step(0, 1, 8'hF0);
        step(0, 1, 8'h23);
        step(1, 0, 8'h00);
        check("after_reset_break", 4'b1100);

        // Stuck right arrow: no break and no repeat make.
        step(0, 1, 8'hE0);
        step(0, 1, 8'h74);
        for (int k = 1; k <= 18; k++) begin
            logic [3:0] e;
`ifdef STUCK_KEY_TIMEOUT_EN
            e = (k >= 17) ? 4'b1100 : 4'b1000;
`else
            e = 4'b1000;
`endif
            step(1, 0, 8'h00);
            step(0, 0, 8'h00);
            check($sformatf("stuck_frame_%0d", k), e);
        end
        step(0, 1, 8'hE0);
        step(0, 1, 8'hF0);
        step(0, 1, 8'h74);
        step(1, 0, 8'h00);
        check("stuck_release", 4'b1100);

        // Random bytes checked every cycle against the model.
        pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h6B; pool[3] = 8'h74;
        pool[4] = 8'h1C; pool[5] = 8'h23; pool[6] = 8'h4D; pool[7] = 8'hAA;
        pool[8] = 8'hF0; pool[9] = 8'hE0;
        for (int n = 0; n < 4000; n++) begin
            bit sof, v;
            logic [7:0] b;
            sof = ($urandom_range(0, 7) == 0);
            v   = ($urandom_range(0, 2) == 0);
            b   = pool[$urandom_range(0, 9)];
            step(sof, v, b);
            check($sformatf("random[%0d]", n), {m_ml, m_mr, m_pause, m_err});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
